// File: rtl/mod_m_updown_counter.sv
// Parametrised mod-M up/down counter with enable, synchronous clear, saturating
// parallel load, registered wrap pulse and combinational terminal count.
module mod_m_updown_counter #(
    parameter int     N = 4,
    parameter longint M = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         wrap
);

    if (N < 1 || N > 32 || M < 2 || M > (longint'(1) << N)) begin : g_param_check
        $error("mod_m_updown_counter: illegal parameters N=%0d M=%0d", N, M);
    end

    // M-1 held in N bits; for M == 2**N this is all ones and the +1 wraps to 0 on its own.
    localparam logic [N-1:0] MAX = N'(M - 1);

    logic [N-1:0] q_nxt;
    logic         wrap_nxt;
    logic         at_top;
    logic         at_bot;

    function automatic logic [N-1:0] sat_load(input logic [N-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    assign at_top = (q == MAX);
    assign at_bot = (q == '0);
    assign tc     = en & ~clr & ~load & (up ? at_top : at_bot);

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = sat_load(load_val);
        end else if (en) begin
            if (up) begin
                q_nxt    = at_top ? '0 : q + N'(1);
                wrap_nxt = at_top;
            end else begin
                q_nxt    = at_bot ? MAX : q - N'(1);
                wrap_nxt = at_bot;
            end
        end
    end

    // count register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// Directed bench for mod_m_updown_counter: M=10 counter, full-range M=8 counter
// and a two-digit cascade of M=10 stages.
module tb_mod_m_updown_counter;

    logic       clk = 1'b0;
    logic       reset_n;

    // main counter N=4, M=10
    logic       en, up, clr, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;

    // full-range counter N=3, M=8
    logic       f_en, f_up, f_clr, f_load;
    logic [2:0] f_load_val;
    logic [2:0] f_q;
    logic       f_tc, f_wrap;

    // cascade stages
    logic       c_en, c_clr;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c0_wrap, c1_tc, c1_wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_m_updown_counter #(.N(4), .M(10)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    mod_m_updown_counter #(.N(3), .M(8)) dut_full (
        .clk(clk), .reset_n(reset_n), .en(f_en), .up(f_up), .clr(f_clr), .load(f_load),
        .load_val(f_load_val), .q(f_q), .tc(f_tc), .wrap(f_wrap)
    );

    mod_m_updown_counter #(.N(4), .M(10)) dut_c0 (
        .clk(clk), .reset_n(reset_n), .en(c_en), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap)
    );

    mod_m_updown_counter #(.N(4), .M(10)) dut_c1 (
        .clk(clk), .reset_n(reset_n), .en(c0_tc), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 0; up = 1; clr = 0; load = 0; load_val = 0;
        f_en = 0; f_up = 1; f_clr = 0; f_load = 0; f_load_val = 0;
        c_en = 0; c_clr = 0;
        reset_n = 0;
        #2;
        total++;
        if (q !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: q=%0d wrap=%b tc=%b, want q=0 wrap=0 tc=0", q, wrap, tc);
        end
        step();
        step();
        reset_n = 1;
        step();
        total++;
        if (q !== 4'd0) begin
            bad++;
            $display("FAIL reset_hold: q=%0d, want 0", q);
        end
        load = 1; load_val = 4'd7;
        step();
        load = 0;
        total++;
        if (q !== 4'd7) begin
            bad++;
            $display("FAIL reset_preload: q=%0d, want 7", q);
        end
        en = 1; up = 1;
        #2;
        reset_n = 0;
        #1;
        total++;
        if (q !== 4'd0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: q=%0d wrap=%b, want q=0 wrap=0", q, wrap);
        end
        #1;
        reset_n = 1;
        step();
        total++;
        if (q !== 4'd1) begin
            bad++;
            $display("FAIL reset_first_edge: q=%0d, want 1", q);
        end
        en = 0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_q [12];
        logic       exp_w [12];
        logic       exp_tc[12];
        exp_q  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        exp_w  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        exp_tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        clr = 1;
        step();
        clr = 0;
        en = 1; up = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if (tc !== exp_tc[i]) begin
                bad++;
                $display("FAIL up_tc[%0d]: q=%0d tc=%b, want tc=%b", i, q, tc, exp_tc[i]);
            end
            step();
            total++;
            if (q !== exp_q[i] || wrap !== exp_w[i]) begin
                bad++;
                $display("FAIL up_wrap[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b",
                         i, q, wrap, exp_q[i], exp_w[i]);
            end
        end
        en = 0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_q [3];
        logic       exp_w [3];
        logic       exp_tc[3];
        exp_q  = '{4'd0, 4'd9, 4'd8};
        exp_w  = '{0, 1, 0};
        exp_tc = '{0, 1, 0};
        load = 1; load_val = 4'd1;
        step();
        load = 0;
        en = 1; up = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (tc !== exp_tc[i]) begin
                bad++;
                $display("FAIL down_tc[%0d]: q=%0d tc=%b, want tc=%b", i, q, tc, exp_tc[i]);
            end
            step();
            total++;
            if (q !== exp_q[i] || wrap !== exp_w[i]) begin
                bad++;
                $display("FAIL down_wrap[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b",
                         i, q, wrap, exp_q[i], exp_w[i]);
            end
        end
        en = 0; up = 1;
    endtask

    task automatic test_load_priority();
        load = 1; load_val = 4'd5;
        step();
        total++;
        if (q !== 4'd5) begin
            bad++;
            $display("FAIL load_5: q=%0d, want 5", q);
        end
        load_val = 4'd13;
        step();
        total++;
        if (q !== 4'd9) begin
            bad++;
            $display("FAIL load_sat: q=%0d, want 9", q);
        end
        // q=9 counting up would wrap and load would give 5; clear must beat both
        load_val = 4'd5; en = 1; up = 1; clr = 1;
        #1;
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL clr_tc: tc=%b, want 0", tc);
        end
        step();
        total++;
        if (q !== 4'd0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority: q=%0d wrap=%b, want q=0 wrap=0", q, wrap);
        end
        clr = 0; load = 0;
        load_val = 4'd3; load = 1; en = 1; up = 0;
        #1;
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL load_tc: tc=%b, want 0", tc);
        end
        step();
        total++;
        if (q !== 4'd3 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_over_en: q=%0d wrap=%b, want q=3 wrap=0", q, wrap);
        end
        load = 0; en = 0; up = 1;
    endtask

    task automatic test_enable();
        logic       en_seq[4];
        logic [3:0] exp_q [4];
        logic       exp_w [4];
        logic       exp_tc[4];
        en_seq = '{1, 0, 0, 1};
        exp_q  = '{4'd9, 4'd9, 4'd9, 4'd0};
        exp_w  = '{0, 0, 0, 1};
        exp_tc = '{0, 0, 0, 1};
        load = 1; load_val = 4'd8;
        step();
        load = 0; up = 1;
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            #1;
            total++;
            if (tc !== exp_tc[i]) begin
                bad++;
                $display("FAIL en_tc[%0d]: tc=%b, want %b", i, tc, exp_tc[i]);
            end
            step();
            total++;
            if (q !== exp_q[i] || wrap !== exp_w[i]) begin
                bad++;
                $display("FAIL en_gate[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b",
                         i, q, wrap, exp_q[i], exp_w[i]);
            end
        end
        en = 0;
        step();
        total++;
        if (wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_one_cycle: wrap=%b, want 0", wrap);
        end
    endtask

    task automatic test_full_range();
        f_load = 1; f_load_val = 3'd7;
        step();
        f_load = 0; f_en = 1; f_up = 1;
        #1;
        total++;
        if (f_q !== 3'd7 || f_tc !== 1'b1) begin
            bad++;
            $display("FAIL full_pre: q=%0d tc=%b, want q=7 tc=1", f_q, f_tc);
        end
        step();
        total++;
        if (f_q !== 3'd0 || f_wrap !== 1'b1) begin
            bad++;
            $display("FAIL full_wrap: q=%0d wrap=%b, want q=0 wrap=1", f_q, f_wrap);
        end
        f_up = 0;
        step();
        total++;
        if (f_q !== 3'd7 || f_wrap !== 1'b1) begin
            bad++;
            $display("FAIL full_down: q=%0d wrap=%b, want q=7 wrap=1", f_q, f_wrap);
        end
        f_en = 0;
    endtask

    task automatic test_cascade();
        int wraps = 0;
        c_clr = 1;
        step();
        c_clr = 0;
        c_en = 1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (c1_wrap === 1'b1) wraps++;
            if (i == 37) begin
                total++;
                if (c1_q !== 4'd3 || c0_q !== 4'd7) begin
                    bad++;
                    $display("FAIL cascade_mid: c1=%0d c0=%0d, want c1=3 c0=7", c1_q, c0_q);
                end
            end
        end
        c_en = 0;
        total++;
        if (c1_q !== 4'd0 || c0_q !== 4'd0 || c1_wrap !== 1'b1) begin
            bad++;
            $display("FAIL cascade_end: c1=%0d c0=%0d c1_wrap=%b, want 0 0 1", c1_q, c0_q, c1_wrap);
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL cascade_wraps: count=%0d, want 1", wraps);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_enable();
        test_full_range();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
